// File: rtl/inport_ioc_bank.sv
// Purpose : interrupt-on-change input bank on the PicoBlaze port bus (sync, debounce, edge flags, mask).
// Latency : port_in change to flag = SYNC_STAGES+DEBOUNCE+1 edges; read data one cycle after ren.
// Backpres: none; bus strobes are single-cycle and always accepted, int_out is a level held until cleared.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-low reset
//   address  port bus address; BASE_ADDR+0..+4 = DATA, POS_EN, NEG_EN, FLAGS (W1C), MASK
//   data_in  port bus write data
//   wen/ren  single-cycle write / read strobes
//   port_in  asynchronous external inputs
//   port_out registered read data (0 when no in-range read)
//   int_out  level interrupt = |(FLAGS & MASK)
//   int_ack  clears every flag
`timescale 1ns/1ps
module inport_ioc_bank #(
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         WIDTH       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         DEBOUNCE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic [7:0]       data_in,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] port_in,
  output logic [7:0]       port_out,
  output logic             int_out,
  input  logic             int_ack
);

  localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] pos_en_q;
  logic [WIDTH-1:0] neg_en_q;
  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] mask_q;

  // Synchroniser chain: stage 0 samples the pin, the last stage feeds the debouncer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_no_db
      assign stable = sync;
    end else begin : g_db
      logic [WIDTH-1:0]         stable_q;
      logic [WIDTH-1:0][CW-1:0] cnt_q;

      // A new level is accepted only after it has differed from the current
      // stable level for DEBOUNCE consecutive cycles; any agreement restarts it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          stable_q <= '0;
          cnt_q    <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != stable_q[i]) begin
              if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                stable_q[i] <= sync[i];
                cnt_q[i]    <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end else begin
              cnt_q[i] <= '0;
            end
          end
        end
      end

      assign stable = stable_q;
    end
  endgenerate

  // Address decode; wrap-around subtraction keeps the range test a single compare.
  logic [7:0] offset;
  logic       in_range;
  assign offset   = address - BASE_ADDR;
  assign in_range = (offset < 8'd5);

  logic [WIDTH-1:0] rise, fall, set_bits, clr_bits, w1c_bits, flags_nxt;
  assign rise      = stable & ~prev_q;
  assign fall      = ~stable & prev_q;
  assign set_bits  = (rise & pos_en_q) | (fall & neg_en_q);
  assign w1c_bits  = (wen && in_range && offset == 8'd3) ? data_in[WIDTH-1:0] : '0;
  assign clr_bits  = w1c_bits | {WIDTH{int_ack}};
  // Set is applied after clear so a fresh edge survives a simultaneous W1C or ack.
  assign flags_nxt = (flags_q & ~clr_bits) | set_bits;

  logic [7:0] rd_val;
  always_comb begin
    rd_val = '0;
    case (offset)
      8'd0:    rd_val[WIDTH-1:0] = stable;
      8'd1:    rd_val[WIDTH-1:0] = pos_en_q;
      8'd2:    rd_val[WIDTH-1:0] = neg_en_q;
      8'd3:    rd_val[WIDTH-1:0] = flags_q;
      8'd4:    rd_val[WIDTH-1:0] = mask_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q   <= '0;
      pos_en_q <= '0;
      neg_en_q <= '0;
      flags_q  <= '0;
      mask_q   <= '0;
      port_out <= '0;
    end else begin
      prev_q   <= stable;
      flags_q  <= flags_nxt;
      // rd_val is built from current register contents, so a same-cycle
      // write is not visible to this read.
      port_out <= (ren && in_range) ? rd_val : 8'h00;
      if (wen && in_range) begin
        case (offset)
          8'd1:    pos_en_q <= data_in[WIDTH-1:0];
          8'd2:    neg_en_q <= data_in[WIDTH-1:0];
          8'd4:    mask_q   <= data_in[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign int_out = |(flags_q & mask_q);

endmodule

// File: tb/tb_inport_ioc_bank.sv
`timescale 1ns/1ps
module tb_inport_ioc_bank;

  localparam logic [7:0] BASE = 8'h03;
  localparam int         S    = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       int_ack = 1'b0;
  logic [7:0] address = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [2:0] port_in = 3'b000;
  logic [7:0] po0, po1;
  logic       io0, io1;

  inport_ioc_bank #(.BASE_ADDR(BASE), .WIDTH(3), .SYNC_STAGES(S), .DEBOUNCE(0)) dut0 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wen(wen), .ren(ren),
    .port_in(port_in), .port_out(po0), .int_out(io0), .int_ack(int_ack));

  inport_ioc_bank #(.BASE_ADDR(BASE), .WIDTH(3), .SYNC_STAGES(S), .DEBOUNCE(4)) dut1 (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .wen(wen), .ren(ren),
    .port_in(port_in), .port_out(po1), .int_out(io1), .int_ack(int_ack));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  // Reference model, one slot per DUT. Pin history, accepted level, previous
  // accepted level, registers, and per-bit length of the current disagreement run.
  logic [2:0] hist [2][S];
  logic [2:0] stab [2];
  logic [2:0] prv  [2];
  logic [2:0] pos  [2];
  logic [2:0] neg  [2];
  logic [2:0] flg  [2];
  logic [2:0] msk  [2];
  int         run  [2][3];
  int         dbv  [2] = '{0, 4};

  logic rd_seen = 1'b0;
  logic mon_en  = 1'b0;
  always @(posedge clk) rd_seen <= ren;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_edge(input int k, output logic [7:0] rdv);
    logic [2:0] sp, st, setv, clrv;
    logic [7:0] off;
    sp  = hist[k][S-1];
    st  = (dbv[k] == 0) ? sp : stab[k];
    off = address - BASE;
    rdv = 8'h00;
    if (ren && off < 8'd5) begin
      case (off)
        8'd0: rdv = {5'b0, st};
        8'd1: rdv = {5'b0, pos[k]};
        8'd2: rdv = {5'b0, neg[k]};
        8'd3: rdv = {5'b0, flg[k]};
        default: rdv = {5'b0, msk[k]};
      endcase
    end
    if (!rst) begin
      rdv = 8'h00;
      for (int j = 0; j < S; j++) hist[k][j] = 3'b000;
      stab[k] = 0; prv[k] = 0; pos[k] = 0; neg[k] = 0; flg[k] = 0; msk[k] = 0;
      for (int b = 0; b < 3; b++) run[k][b] = 0;
    end else begin
      setv = ((st & ~prv[k]) & pos[k]) | ((~st & prv[k]) & neg[k]);
      clrv = int_ack ? 3'b111 : ((wen && off == 8'd3) ? data_in[2:0] : 3'b000);
      flg[k] = (flg[k] & ~clrv) | setv;
      if (wen) begin
        if (off == 8'd1) pos[k] = data_in[2:0];
        if (off == 8'd2) neg[k] = data_in[2:0];
        if (off == 8'd4) msk[k] = data_in[2:0];
      end
      if (dbv[k] > 0) begin
        for (int b = 0; b < 3; b++) begin
          if (sp[b] != stab[k][b]) begin
            run[k][b]++;
            if (run[k][b] == dbv[k]) begin
              stab[k][b] = sp[b];
              run[k][b]  = 0;
            end
          end else begin
            run[k][b] = 0;
          end
        end
      end
      prv[k] = st;
      for (int j = S - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = port_in;
    end
  endtask

  task automatic tick();
    logic [7:0] r0, r1;
    rd_exp_t e;
    @(posedge clk);
    model_edge(0, r0);
    model_edge(1, r1);
    if (ren) begin
      e.e0 = r0;
      e.e1 = r1;
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    address = BASE + off; data_in = d; wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off);
    address = BASE + off; ren = 1'b1;
    tick();
    ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Monitor: pops an expectation whenever a read was presented the edge before.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_underflow: got read data with no expectation at %0t", $time);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("port_out_db0", po0, e.e0);
          chk("port_out_db4", po1, e.e1);
        end
      end else begin
        chk("port_out_idle_db0", po0, 8'h00);
        chk("port_out_idle_db4", po1, 8'h00);
      end
      chk("int_out_db0", {7'b0, io0}, {7'b0, |(flg[0] & msk[0])});
      chk("int_out_db4", {7'b0, io1}, {7'b0, |(flg[1] & msk[1])});
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < S; j++) hist[k][j] = 3'b000;
      stab[k] = 0; prv[k] = 0; pos[k] = 0; neg[k] = 0; flg[k] = 0; msk[k] = 0;
      for (int b = 0; b < 3; b++) run[k][b] = 0;
    end

    // Reset with all pins high, then read every register.
    rst = 1'b0; port_in = 3'b111;
    tick();
    mon_en = 1'b1;
    rst = 1'b1;
    for (int r = 0; r < 5; r++) rd(8'(r));
    idle(9);
    rd(8'd3);

    // Rising edges with POS_EN/MASK enabled; poll FLAGS every cycle.
    port_in = 3'b000;
    idle(9);
    wr(8'd1, 8'h07);
    wr(8'd4, 8'h07);
    port_in = 3'b101;
    for (int r = 0; r < 9; r++) rd(8'd3);
    rd(8'd0);

    // W1C one bit at a time.
    wr(8'd3, 8'h01);
    rd(8'd3);
    wr(8'd3, 8'h04);
    rd(8'd3);
    idle(1);

    // Falling edges with partial mask, then retarget mask and ack.
    wr(8'd2, 8'h07);
    wr(8'd4, 8'h02);
    port_in = 3'b000;
    idle(9);
    rd(8'd3);
    wr(8'd4, 8'h01);
    idle(1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    rd(8'd3);

    // Upper bits, out-of-range writes, write to DATA, read-during-write.
    wr(8'd1, 8'hFF);
    wr(8'd5, 8'h00);
    wr(8'hFF, 8'h00);
    wr(8'd0, 8'hFF);
    rd(8'd1);
    rd(8'd5);
    address = BASE + 8'd4; data_in = 8'h06; wen = 1'b1; ren = 1'b1;
    tick();
    wen = 1'b0; ren = 1'b0;
    rd(8'd4);

    // Three-cycle glitch on bit0, then a held high level.
    port_in = 3'b001; idle(3);
    port_in = 3'b000; idle(9);
    rd(8'd0);
    rd(8'd3);
    port_in = 3'b001;
    for (int r = 0; r < 9; r++) rd(8'd3);
    rd(8'd0);

    // Edge detected on the same edge as a W1C of that bit (no debounce).
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    port_in = 3'b111;
    idle(2);
    wr(8'd3, 8'h07);
    rd(8'd3);
    idle(9);
    // Same collision for the debounced instance (7-edge latency).
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    port_in = 3'b011;
    idle(6);
    wr(8'd3, 8'h07);
    rd(8'd3);

    // Reset mid-operation with flags pending and debounce counts in progress.
    wr(8'd4, 8'h07);
    port_in = ~port_in;
    idle(9);
    rd(8'd3);
    port_in = ~port_in;
    idle(3);
    rst = 1'b0; tick(); rst = 1'b1;
    for (int r = 0; r < 5; r++) rd(8'(r));
    idle(10);
    rd(8'd0);
    rd(8'd3);

    // Randomised traffic.
    repeat (2000) begin
      address = BASE - 8'd1 + 8'($urandom_range(0, 6));
      data_in = 8'($urandom);
      wen     = ($urandom % 4) == 0;
      ren     = ($urandom % 2) == 0;
      int_ack = ($urandom % 25) == 0;
      rst     = ($urandom % 300) != 0;
      if (($urandom % 5) == 0) port_in = 3'($urandom);
      tick();
    end
    wen = 1'b0; ren = 1'b0; int_ack = 1'b0; rst = 1'b1;
    idle(3);
    chk("exp_q_drained", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inport_ioc_bank.md
Name: inport_ioc_bank

Overview:
- Parametrised successor to the single-register interrupt-on-change input port.
- Sits on the PicoBlaze port bus.
- Adds input synchronisation, optional per-bit debounce, and software-writable configuration: per-bit rising/falling enables, interrupt flags (write-1-to-clear), and an interrupt mask.
- Drives one level interrupt to the core and accepts the core's int_ack.

Parameters:
- BASE_ADDR, 8'h03: address of register 0. The block decodes BASE_ADDR..BASE_ADDR+4.
- WIDTH, 8: number of input bits, legal range 1..8.
- SYNC_STAGES, 2: flip-flop synchroniser depth per bit, legal range 2..4.
- DEBOUNCE, 0: consecutive cycles a new level must persist before it is accepted. 0 bypasses the debouncer. Legal range 0..255.

Ports:
- clk, input, 1: single system clock. All state changes on the rising edge.
- rst, input, 1: reset, synchronous, active-low. Sampled on the clk rising edge; rst=0 resets the block.
- address, input, 8: port bus address.
- data_in, input, 8: port bus write data.
- wen, input, 1: write strobe, one cycle.
- ren, input, 1: read strobe, one cycle.
- port_in, input, WIDTH: asynchronous external inputs.
- port_out, output, 8: registered read data.
- int_out, output, 1: interrupt request, level.
- int_ack, input, 1: interrupt acknowledge; clears all flags.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0 DATA: RO, debounced input level.
  - +1 POS_EN: RW.
  - +2 NEG_EN: RW.
  - +3 FLAGS: read; write 1 to clear.
  - +4 MASK: RW.
- Register bits [7:WIDTH] read 0; writes to them are ignored.
- Reset (rst=0 at a rising edge): all internal state cleared to 0. This covers synchroniser stages, debounce counters, stable and previous-stable registers, POS_EN, NEG_EN, FLAGS and MASK. port_out=0 and int_out=0.
  - Because enables reset to 0, no flag can set on the first edge after reset.
  - Reset asserted mid-operation clears any pending flags and any debounce count in progress.
- Synchroniser: port_in passes through SYNC_STAGES flops; the output is sync[i].
- Debounce, per bit:
  - DEBOUNCE=0: stable[i] = sync[i].
  - Otherwise, when sync[i] != stable[i], the counter increments each cycle. When the counter reaches DEBOUNCE-1 and the bits still differ, stable[i] <= sync[i] and the counter resets to 0.
  - Any cycle with sync[i] == stable[i] resets the counter to 0.
  - Counter width is ceil(log2(DEBOUNCE+1)).
- Edge detection:
  - prev <= stable every cycle.
  - rise = stable & ~prev.
  - fall = ~stable & prev.
- Flag update, per bit, each cycle:
  - The flag sets if (rise & POS_EN) | (fall & NEG_EN).
  - The flag clears on a W1C write of 1 to FLAGS, or on int_ack=1.
  - Set wins over clear in the same cycle.
- int_out = |(FLAGS & MASK), combinational from registers.
  - It asserts in the cycle after a flag sets.
  - It responds in the cycle after a MASK write.
- Latency, port_in change to flag set: SYNC_STAGES + DEBOUNCE + 1 rising edges. With defaults this is 3 edges.
- Write: on a rising edge with wen=1 and address in range, the selected register is updated.
  - Writes to DATA are ignored.
  - Writes to addresses outside the range are ignored.
- Read: on each rising edge, if ren=1 and address is in range, port_out <= the selected register value; otherwise port_out <= 0.
  - Read latency is one cycle.
  - Reading FLAGS does not clear it.
- ren and wen asserted in the same cycle: the read returns the pre-write value.

Test Plan:
1. Reset: WIDTH=3, drive rst=0 for 1 cycle with port_in=3'b111 -> all five registers read 8'h00 and int_out=0. After release, with enables at 0, FLAGS stays 8'h00.
2. Rising edge, DEBOUNCE=0: write POS_EN=8'h07 and MASK=8'h07, then change port_in 3'b000->3'b101 -> FLAGS=8'h05 on the 3rd edge and int_out=1 one cycle later. Reading DATA returns 8'h05.
3. W1C: from scenario 2, write FLAGS=8'h01 -> FLAGS=8'h04 and int_out stays 1. Write FLAGS=8'h04 -> FLAGS=8'h00 and int_out=0 the next cycle.
4. Falling edge with mask: write NEG_EN=8'h07 and MASK=8'h02, then change port_in 3'b101->3'b000 -> FLAGS=8'h05 and int_out=0. Write MASK=8'h01 -> int_out=1. Pulse int_ack -> FLAGS=8'h00 and int_out=0.
5. Debounce, DEBOUNCE=4: a 3-cycle glitch on bit0 -> DATA unchanged and no flag. Holding bit0 high -> DATA bit0=1 and the flag sets at edge 2+4+1=7.
6. Collisions:
   - An edge detected in the same cycle as a W1C of that bit -> the flag remains 1.
   - rst=0 while FLAGS=8'h07 -> FLAGS=8'h00, int_out=0, and the debounce counters are cleared.
